// File: rtl/io_port_buffer.sv
// io_port_buffer: buffered I/O port between the processor memory stage and the
// outside world. Stores are queued in an output FIFO drained over valid/ready;
// external words are queued in an input FIFO consumed by processor loads.
// The pipeline is stalled when a store meets a full output FIFO or a load
// meets an empty input FIFO. Both FIFOs are show-ahead (head visible without
// a read strobe); full/empty decisions use the registered occupancy only.
module io_port_buffer #(
  parameter int WIDTH     = 16,
  parameter int OUT_DEPTH = 4,
  parameter int IN_DEPTH  = 4
) (
  input  logic                        clock,
  input  logic                        rst,
  input  logic                        cpu_write,
  input  logic [WIDTH-1:0]            cpu_wdata,
  input  logic                        cpu_read,
  output logic [WIDTH-1:0]            cpu_rdata,
  output logic                        io_stall,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  input  logic [WIDTH-1:0]            in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [$clog2(OUT_DEPTH):0]  out_count,
  output logic [$clog2(IN_DEPTH):0]   in_count
);

  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OCW = OAW + 1;
  localparam int ICW = IAW + 1;

  localparam logic [OCW-1:0] OUT_FULL_CNT = OCW'(OUT_DEPTH);
  localparam logic [ICW-1:0] IN_FULL_CNT  = ICW'(IN_DEPTH);
  localparam logic [OAW-1:0] OUT_PTR_ONE  = OAW'(1);
  localparam logic [IAW-1:0] IN_PTR_ONE   = IAW'(1);
  localparam logic [OCW-1:0] OUT_CNT_ONE  = OCW'(1);
  localparam logic [ICW-1:0] IN_CNT_ONE   = ICW'(1);

  // Storage (contents are don't-care after reset, so no reset on these)
  logic [WIDTH-1:0] out_mem [OUT_DEPTH];
  logic [WIDTH-1:0] in_mem  [IN_DEPTH];

  // Pointers
  logic [OAW-1:0] out_wr_ptr;
  logic [OAW-1:0] out_rd_ptr;
  logic [IAW-1:0] in_wr_ptr;
  logic [IAW-1:0] in_rd_ptr;

  // Status flags derived from registered counts
  logic out_full;
  logic out_empty;
  logic in_full;
  logic in_empty;

  // Per-cycle transfer strobes
  logic out_push;
  logic out_pop;
  logic in_push;
  logic in_pop;

  // Flags, handshake outputs and processor-side strobes. A stall on either
  // processor op blocks both processor-side transfers; external handshakes
  // are independent of the stall.
  always_comb begin
    out_full  = (out_count == OUT_FULL_CNT);
    out_empty = (out_count == '0);
    in_full   = (in_count == IN_FULL_CNT);
    in_empty  = (in_count == '0);

    io_stall  = (cpu_write && out_full) || (cpu_read && in_empty);

    out_valid = !out_empty;
    in_ready  = !in_full;

    out_push  = cpu_write && !out_full && !io_stall;
    in_pop    = cpu_read  && !in_empty && !io_stall;
    out_pop   = out_valid && out_ready;
    in_push   = in_valid  && in_ready;

    out_data  = out_empty ? '0 : out_mem[out_rd_ptr];
    cpu_rdata = in_empty  ? '0 : in_mem[in_rd_ptr];
  end

  // Storage writes: one register per entry, enabled when the write pointer
  // selects it.
  generate
    for (genvar gi = 0; gi < OUT_DEPTH; gi++) begin : g_out_mem
      // Capture store data into output entry gi
      always_ff @(posedge clock) begin
        if (out_push && (out_wr_ptr == OAW'(gi))) begin
          out_mem[gi] <= cpu_wdata;
        end
      end
    end
    for (genvar gi = 0; gi < IN_DEPTH; gi++) begin : g_in_mem
      // Capture external input data into input entry gi
      always_ff @(posedge clock) begin
        if (in_push && (in_wr_ptr == IAW'(gi))) begin
          in_mem[gi] <= in_data;
        end
      end
    end
  endgenerate

  // Output FIFO pointers and occupancy; pointers wrap modulo the power-of-2 depth
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      out_wr_ptr <= '0;
      out_rd_ptr <= '0;
      out_count  <= '0;
    end else begin
      if (out_push) out_wr_ptr <= out_wr_ptr + OUT_PTR_ONE;
      if (out_pop)  out_rd_ptr <= out_rd_ptr + OUT_PTR_ONE;
      case ({out_push, out_pop})
        2'b10:   out_count <= out_count + OUT_CNT_ONE;
        2'b01:   out_count <= out_count - OUT_CNT_ONE;
        default: out_count <= out_count;
      endcase
    end
  end

  // Input FIFO pointers and occupancy; pointers wrap modulo the power-of-2 depth
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      in_wr_ptr <= '0;
      in_rd_ptr <= '0;
      in_count  <= '0;
    end else begin
      if (in_push) in_wr_ptr <= in_wr_ptr + IN_PTR_ONE;
      if (in_pop)  in_rd_ptr <= in_rd_ptr + IN_PTR_ONE;
      case ({in_push, in_pop})
        2'b10:   in_count <= in_count + IN_CNT_ONE;
        2'b01:   in_count <= in_count - IN_CNT_ONE;
        default: in_count <= in_count;
      endcase
    end
  end

endmodule
